lfsr_descrambler: RTL

Additive (frame-synchronous) descrambler: the receive-side counterpart of the team's parallel LFSR scrambler. It regenerates the same keystream from the same seed and polynomial, XORs it onto incoming words, and runs a lock state machine. The lock machine reseeds the keystream on a frame-sync marker and confirms alignment against a zero-plaintext training preamble. It sits between the deserializer/word aligner and the frame parser; only payload words decoded while locked are forwarded.

---
 rtl/lfsr_descrambler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lfsr_descrambler.sv
// rtl/lfsr_descrambler.sv - additive LFSR descrambler with sync/training lock FSM
// Regenerates the scrambler keystream, strips it from incoming words and forwards payload once locked.
module lfsr_descrambler #(
   parameter int unsigned p_BITS_PER_CLOCK = 8,
   parameter logic [15:0] p_RESET_SEED     = 16'hFFFF,
   parameter logic [15:0] p_POLYNOMIAL     = 16'b1000_0000_0001_1100,
   parameter int unsigned p_TRAIN_WORDS    = 2
) (
   input  logic                        i_CLK,
   input  logic                        i_RESET_N,
   input  logic                        i_VALID,
   input  logic                        i_SYNC,
   input  logic [p_BITS_PER_CLOCK-1:0] i_DATA_IN,
   output logic                        o_VALID,
   output logic [p_BITS_PER_CLOCK-1:0] o_DATA_OUT,
   output logic                        o_LOCKED,
   output logic [7:0]                  o_ERR_CNT
);

   typedef enum logic [1:0] {ST_HUNT, ST_CHECK, ST_LOCKED} state_t;

   state_t                      state_q, state_d;
   logic [15:0]                 lfsr_q, lfsr_d;
   logic [7:0]                  train_cnt_q, train_cnt_d;
   logic [7:0]                  err_cnt_q, err_cnt_d;
   logic [p_BITS_PER_CLOCK-1:0] data_q, data_d;
   logic                        valid_q, valid_d;
   logic                        locked_q, locked_d;

   logic [15:0]                 walk;
   logic [15:0]                 lfsr_adv;
   logic [p_BITS_PER_CLOCK-1:0] ks_word;
   logic [p_BITS_PER_CLOCK-1:0] decoded;
   logic                        word_zero;
   logic [7:0]                  err_inc;
   logic [7:0]                  train_inc;

   // A sync word restarts the keystream from the seed in the same cycle it is decoded.
   always_comb begin
      walk    = (i_VALID && i_SYNC) ? p_RESET_SEED : lfsr_q;
      ks_word = '0;
      for (int j = 0; j < int'(p_BITS_PER_CLOCK); j++) begin
         ks_word[j] = walk[15];
         walk       = {walk[14:0], ^(walk & p_POLYNOMIAL)};
      end
      lfsr_adv = walk;
   end

   assign decoded   = i_DATA_IN ^ ks_word;
   assign word_zero = (decoded == '0);
   assign err_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
   assign train_inc = train_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      train_cnt_d = train_cnt_q;
      err_cnt_d   = err_cnt_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      if (i_VALID) begin
         lfsr_d = lfsr_adv;
         if (i_SYNC) begin
            // The sync word is itself the first training word.
            train_cnt_d = 8'd1;
            if (!word_zero) begin
               state_d   = ST_HUNT;
               err_cnt_d = err_inc;
            end else if (p_TRAIN_WORDS == 1) begin
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_CHECK;
            end
         end else begin
            case (state_q)
               ST_CHECK: begin
                  if (!word_zero) begin
                     state_d     = ST_HUNT;
                     err_cnt_d   = err_inc;
                     train_cnt_d = 8'd0;
                  end else begin
                     train_cnt_d = train_inc;
                     if (train_inc == 8'(p_TRAIN_WORDS)) begin
                        state_d = ST_LOCKED;
                     end
                  end
               end
               ST_LOCKED: begin
                  valid_d = 1'b1;
                  data_d  = decoded;
               end
               default: begin
               end
            endcase
         end
      end
      locked_d = (state_d == ST_LOCKED);
   end

   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         state_q     <= ST_HUNT;
         lfsr_q      <= p_RESET_SEED;
         train_cnt_q <= 8'd0;
         err_cnt_q   <= 8'd0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         train_cnt_q <= train_cnt_d;
         err_cnt_q   <= err_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
      end
   end

   assign o_VALID    = valid_q;
   assign o_DATA_OUT = data_q;
   assign o_LOCKED   = locked_q;
   assign o_ERR_CNT  = err_cnt_q;

endmodule
